ram_transfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single inner/outer RAM transfer engine between three requesters: requester 0 is the scalar multiplication controller, requester 1 the point-double unit and requester 2 the point-add unit. It latches one requester's read/write command and addresses, issues a single `cmd_transfer` pulse to the engine and waits for `interupt_ram_transfer`. It then returns a per-requester completion pulse. A watchdog guarantees forward progress if the engine never completes.

---
 rtl/ram_transfer_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram_transfer_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_transfer_arbiter.sv
// ram_transfer_arbiter: round-robin owner selection for the shared inner/outer
// RAM transfer engine. Requesters: 0 = scalar-mult controller, 1 = point double,
// 2 = point add. One start pulse per grant, one done pulse per completion, and a
// sticky watchdog flag when the engine fails to complete in time.
module ram_transfer_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_cmd,
  input  logic [2:0]  req_rw,
  input  logic [17:0] req_rd_addr,
  input  logic [17:0] req_wr_addr,
  input  logic        interupt_ram_transfer,
  output logic        cmd_transfer,
  output logic        read_write_command,
  output logic [5:0]  read_address,
  output logic [5:0]  write_address,
  output logic [2:0]  grant,
  output logic [2:0]  interupt_done,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value on which the watchdog fires (WAIT then lasts TIMEOUT_CYCLES cycles).
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_transfer_q, cmd_transfer_d;
  logic        rw_q, rw_d;
  logic [5:0]  rd_addr_q, rd_addr_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;

  logic        sel_valid_s;
  logic [1:0]  sel_idx_s;
  logic [1:0]  grant_idx_s;

  // (base + off) mod 3 for base, off in 0..2.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      rr_idx = 2'(sum - 3'd3);
    end else begin
      rr_idx = sum[1:0];
    end
  endfunction

  // Extract requester idx's 6-bit field from a packed address bus.
  function automatic logic [5:0] pick6(input logic [17:0] bus, input logic [1:0] idx);
    case (idx)
      2'd0:    pick6 = bus[5:0];
      2'd1:    pick6 = bus[11:6];
      2'd2:    pick6 = bus[17:12];
      default: pick6 = 6'd0;
    endcase
  endfunction

  // Round-robin search starting at ptr for the first active request.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!sel_valid_s && req_cmd[rr_idx(ptr_q, 2'(i))]) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = rr_idx(ptr_q, 2'(i));
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Index of the current owner, derived from the one-hot grant.
  always_comb begin
    if (grant_q[2]) begin
      grant_idx_s = 2'd2;
    end else if (grant_q[1]) begin
      grant_idx_s = 2'd1;
    end else begin
      grant_idx_s = 2'd0;
    end
  end

  // Next-state and output computation for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    cmd_transfer_d = 1'b0;
    rw_d           = rw_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    grant_d        = grant_q;
    done_d         = 3'b000;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s) begin
          grant_d        = 3'b001 << sel_idx_s;
          rw_d           = req_rw[sel_idx_s];
          rd_addr_d      = pick6(req_rd_addr, sel_idx_s);
          wr_addr_d      = pick6(req_wr_addr, sel_idx_s);
          cmd_transfer_d = 1'b1;
          cnt_d          = 16'd0;
          state_d        = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (interupt_ram_transfer) begin
          // Completion beats a coincident timeout: no error flagged.
          done_d  = grant_q;
          ptr_d   = rr_idx(grant_idx_s, 2'd1);
          grant_d = 3'b000;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          done_d        = grant_q;
          ptr_d         = rr_idx(grant_idx_s, 2'd1);
          grant_d       = 3'b000;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        // One dead cycle so a requester dropping its level late is not re-served.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= 2'd0;
      cnt_q          <= 16'd0;
      cmd_transfer_q <= 1'b0;
      rw_q           <= 1'b0;
      rd_addr_q      <= 6'd0;
      wr_addr_q      <= 6'd0;
      grant_q        <= 3'b000;
      done_q         <= 3'b000;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      cmd_transfer_q <= cmd_transfer_d;
      rw_q           <= rw_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign cmd_transfer       = cmd_transfer_q;
  assign read_write_command = rw_q;
  assign read_address       = rd_addr_q;
  assign write_address      = wr_addr_q;
  assign grant              = grant_q;
  assign interupt_done      = done_q;
  assign busy               = busy_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_ram_transfer_arbiter.sv
// Scoreboard bench for ram_transfer_arbiter: a transaction-level model predicts
// each grant and completion (with its cycle); a monitor compares DUT outputs.
module tb_ram_transfer_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_v = 3'b000;
  logic [2:0]  rw_v = 3'b000;
  logic [5:0]  rd_v [3];
  logic [5:0]  wr_v [3];
  logic        irq = 1'b0;

  logic        cmd_transfer, read_write_command, busy, timeout_err;
  logic [5:0]  read_address, write_address;
  logic [2:0]  grant, interupt_done;

  ram_transfer_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_cmd(req_v), .req_rw(rw_v),
    .req_rd_addr({rd_v[2], rd_v[1], rd_v[0]}),
    .req_wr_addr({wr_v[2], wr_v[1], wr_v[0]}),
    .interupt_ram_transfer(irq),
    .cmd_transfer(cmd_transfer), .read_write_command(read_write_command),
    .read_address(read_address), .write_address(write_address),
    .grant(grant), .interupt_done(interupt_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic       rw;
    logic [5:0] rd;
    logic [5:0] wr;
    logic       err;
  } exp_t;

  exp_t cmd_q[$];
  exp_t done_q[$];

  int   cyc = 0;
  bit   rst_q = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ptr_m = 0;
  bit   err_m = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   cur_v = 1'b0;
  bit   err_mon = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("reset_outputs",
          {cmd_transfer, read_write_command, read_address, write_address, grant, interupt_done, busy, timeout_err},
          32'd0);
      cur_v   = 1'b0;
      err_mon = 1'b0;
    end else begin
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        chk("missing_cmd", 32'(cmd_q[0].cyc), 32'(cyc));
        void'(cmd_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        chk("missing_done", 32'(done_q[0].cyc), 32'(cyc));
        void'(done_q.pop_front());
      end
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        e = cmd_q.pop_front();
        chk("cmd_pulse", 32'(cmd_transfer), 32'd1);
        chk("grant", 32'(grant), 32'(e.g));
        chk("rw", 32'(read_write_command), 32'(e.rw));
        chk("rd_addr", 32'(read_address), 32'(e.rd));
        chk("wr_addr", 32'(write_address), 32'(e.wr));
        cur   = e;
        cur_v = 1'b1;
      end else if (cmd_transfer !== 1'b0) begin
        chk("unexpected_cmd", 32'(cmd_transfer), 32'd0);
      end
      if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
        e = done_q.pop_front();
        chk("done_pulse", 32'(interupt_done), 32'(e.g));
        chk("timeout_err_at_done", 32'(timeout_err), 32'(e.err));
        chk("grant_cleared_in_done", 32'(grant), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        err_mon = e.err;
        cur_v   = 1'b0;
      end else begin
        if (interupt_done !== 3'b000) chk("unexpected_done", 32'(interupt_done), 32'd0);
        if (cur_v) begin
          if ({grant, read_write_command, read_address, write_address, busy} !==
              {cur.g, cur.rw, cur.rd, cur.wr, 1'b1})
            chk("wait_stable", {grant, read_write_command, read_address, write_address, busy},
                {cur.g, cur.rw, cur.rd, cur.wr, 1'b1});
        end else begin
          if ({grant, busy} !== 4'd0) chk("idle_outputs", 32'({grant, busy}), 32'd0);
        end
        if (timeout_err !== err_mon) chk("timeout_err_sticky", 32'(timeout_err), 32'(err_mon));
      end
    end
  end

  // ---------------- model & stimulus ----------------
  function automatic int pick_winner();
    for (int i = 0; i < 3; i++)
      if (req_v[(ptr_m + i) % 3]) return (ptr_m + i) % 3;
    return -1;
  endfunction

  task automatic do_reset(input int n);
    rst   = 1'b1;
    irq   = 1'b0;
    req_v = 3'b000;
    repeat (n) @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    err_m = 1'b0;
    cmd_q.delete();
    done_q.delete();
  endtask

  task automatic new_req(input int i);
    req_v[i] = 1'b1;
    rw_v[i]  = 1'($urandom_range(0, 1));
    rd_v[i]  = 6'($urandom_range(0, 63));
    wr_v[i]  = 6'($urandom_range(0, 63));
  endtask

  // Called at a negedge with the DUT idle. dly = edges after grant at which the
  // engine interrupts (0 = never). Returns at a negedge with the DUT idle again.
  task automatic run_txn(input bit keep_req, input int dly, input bit perturb);
    int   w, k, tdone;
    bit   to;
    exp_t e;
    w = pick_winner();
    if (w < 0) begin
      irq = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      irq = 1'b0;
      return;
    end
    k  = cyc + 1;
    to = (dly == 0) || (dly > TO);
    tdone = to ? k + TO : k + dly;
    err_m = err_m | to;
    e.cyc = k; e.g = 3'(1 << w); e.rw = rw_v[w]; e.rd = rd_v[w]; e.wr = wr_v[w]; e.err = 1'b0;
    cmd_q.push_back(e);
    e.cyc = tdone; e.err = err_m;
    done_q.push_back(e);
    ptr_m = (w + 1) % 3;
    @(negedge clk);
    while (cyc < tdone) begin
      irq = (dly != 0) && (cyc + 1 == k + dly);
      if (perturb) begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            rd_v[i] = 6'($urandom_range(0, 63));
            wr_v[i] = 6'($urandom_range(0, 63));
            rw_v[i] = ~rw_v[i];
          end
          if (i != w && $urandom_range(0, 3) == 0) req_v[i] = ~req_v[i];
        end
      end
      @(negedge clk);
    end
    irq = perturb ? 1'($urandom_range(0, 1)) : 1'b0;  // stray pulse in DONE
    if (!keep_req) req_v[w] = 1'b0;
    @(negedge clk);
    irq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd_v[i] = 6'd0;
      wr_v[i] = 6'd0;
    end
    do_reset(3);

    // Stray interrupt while idle.
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    repeat (2) @(negedge clk);

    // Single request from the point-double unit.
    req_v[1] = 1'b1; rw_v[1] = 1'b1; rd_v[1] = 6'h03; wr_v[1] = 6'h21;
    run_txn(1'b0, 5, 1'b0);
    repeat (2) @(negedge clk);

    // Fairness: all three held for six transfers.
    do_reset(1);
    for (int i = 0; i < 3; i++) new_req(i);
    repeat (6) run_txn(1'b1, $urandom_range(1, 4), 1'b0);
    req_v = 3'b000;
    @(negedge clk);

    // Interrupt coincident with timeout, then a real timeout, then a clean one.
    do_reset(1);
    new_req(2);
    run_txn(1'b0, TO, 1'b0);
    new_req(0);
    run_txn(1'b0, 0, 1'b0);
    new_req(1);
    run_txn(1'b0, 3, 1'b0);
    do_reset(2);

    // Input stability: inputs perturbed during WAIT.
    new_req(0);
    new_req(2);
    run_txn(1'b0, 6, 1'b1);
    req_v[2] = 1'b1;
    run_txn(1'b0, 4, 1'b1);
    req_v = 3'b000;
    @(negedge clk);

    // Reset mid-WAIT followed by a late engine interrupt.
    begin
      exp_t e;
      int   w;
      new_req(1);
      w = pick_winner();
      e.cyc = cyc + 1; e.g = 3'(1 << w); e.rw = rw_v[w]; e.rd = rd_v[w]; e.wr = wr_v[w]; e.err = 1'b0;
      cmd_q.push_back(e);
      repeat (3) @(negedge clk);
      do_reset(1);
      irq = 1'b1;
      @(negedge clk);
      irq = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++)
        if (!req_v[i] && $urandom_range(0, 1) == 1) new_req(i);
      run_txn(1'($urandom_range(0, 3) == 0), $urandom_range(0, 11), 1'b1);
    end

    req_v = 3'b000;
    repeat (4) @(negedge clk);
    chk("pending_cmd", 32'(cmd_q.size()), 32'd0);
    chk("pending_done", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
